// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared MDU op codes, FSM state encoding and widths for the MDU issue controller.
package mdu_issue_ctrl_pkg;

    localparam int unsigned OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8,
        MDU_MADDU = 4'd9
    } mdu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/mdu_issue_ctrl_op_class.sv
// mdu_op_class: combinational classifier of an MDU op code.
// Ports:
//   op_i        decoded MDU op (codes above MADDU behave as NONE)
//   is_long_o   multi-cycle op (mult/multu/maddu/div/divu)
//   is_write_o  op writes HI/LO (long ops plus MTHI/MTLO)
//   is_read_o   op reads HI/LO (MFHI/MFLO)
//   latency_o   busy cycles for a long op, 0 otherwise
module mdu_op_class
    import mdu_issue_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 5
) (
    input  logic [OP_W-1:0]  op_i,
    output logic             is_long_o,
    output logic             is_write_o,
    output logic             is_read_o,
    output logic [CNT_W-1:0] latency_o
);

    always_comb begin
        is_long_o  = 1'b0;
        is_write_o = 1'b0;
        is_read_o  = 1'b0;
        latency_o  = '0;
        case (op_i)
            OP_W'(MDU_MULT), OP_W'(MDU_MULTU), OP_W'(MDU_MADDU): begin
                is_long_o  = 1'b1;
                is_write_o = 1'b1;
                latency_o  = CNT_W'(MULT_CYCLES);
            end
            OP_W'(MDU_DIV), OP_W'(MDU_DIVU): begin
                is_long_o  = 1'b1;
                is_write_o = 1'b1;
                latency_o  = CNT_W'(DIV_CYCLES);
            end
            OP_W'(MDU_MTHI), OP_W'(MDU_MTLO): is_write_o = 1'b1;
            OP_W'(MDU_MFHI), OP_W'(MDU_MFLO): is_read_o  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: issue-side MDU controller. Gates the E-stage op onto the
// MDU enable/op pair, tracks the busy countdown of long ops and stalls D
// while any MDU-class instruction would collide with an op in flight.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   d_valid, d_op     D-stage instruction valid / MDU op
//   e_valid, e_op     E-stage instruction valid / MDU op
//   flush             kills the E-stage instruction this cycle
//   enMDU, rdMDU      write-class / read-class issue (comb)
//   MDUOp             op forwarded to the MDU, NONE when not issuing (comb)
//   start             long op launched this cycle (comb)
//   busy, remain      long op in flight / cycles left (registered)
//   stall_d           freeze PC/D, bubble into E (comb)
//   stall_cnt         saturating count of stall_d cycles (registered)
module mdu_issue_ctrl
    import mdu_issue_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_valid,
    input  logic [3:0]       d_op,
    input  logic             e_valid,
    input  logic [3:0]       e_op,
    input  logic             flush,
    output logic             enMDU,
    output logic             rdMDU,
    output logic [3:0]       MDUOp,
    output logic             start,
    output logic             busy,
    output logic [CNT_W-1:0] remain,
    output logic             stall_d,
    output logic [31:0]      stall_cnt
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   remain_q, remain_d;
    logic [31:0]        stall_cnt_q, stall_cnt_d;

    logic               d_long, d_write, d_read;
    logic [CNT_W-1:0]   d_lat;
    logic               e_long, e_write, e_read;
    logic [CNT_W-1:0]   e_lat;
    logic               live;
    logic               unused_d_class;

    mdu_op_class #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_d_class (
        .op_i       (d_op),
        .is_long_o  (d_long),
        .is_write_o (d_write),
        .is_read_o  (d_read),
        .latency_o  (d_lat)
    );

    mdu_op_class #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_e_class (
        .op_i       (e_op),
        .is_long_o  (e_long),
        .is_write_o (e_write),
        .is_read_o  (e_read),
        .latency_o  (e_lat)
    );

    // D side only needs "is MDU-class"; long/latency are subsumed by write.
    assign unused_d_class = d_long ^ (^d_lat);

    // Issue gate: flush suppresses all issue for this cycle.
    assign live    = e_valid & ~flush;
    assign enMDU   = live & e_write;
    assign rdMDU   = live & e_read;
    assign MDUOp   = (enMDU | rdMDU) ? e_op : OP_W'(MDU_NONE);
    assign start   = live & e_long & (state_q == S_IDLE);
    assign busy    = (state_q == S_BUSY);
    assign remain  = remain_q;
    // Including start lets a D-stage MDU op wait on a launch in this same cycle.
    assign stall_d = d_valid & (d_write | d_read) & (busy | start);
    assign stall_cnt = stall_cnt_q;

    // State, countdown and stall counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            remain_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            remain_q    <= remain_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next state: load latency on start, count down to 1, then idle with remain=0.
    always_comb begin
        state_d     = state_q;
        remain_d    = remain_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_BUSY;
                    remain_d = e_lat;
                end
            end
            S_BUSY: begin
                if (remain_q <= CNT_W'(1)) begin
                    state_d  = S_IDLE;
                    remain_d = '0;
                end else begin
                    remain_d = remain_q - CNT_W'(1);
                end
            end
            default: begin
                state_d  = S_IDLE;
                remain_d = '0;
            end
        endcase
        if (stall_d && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
module tb_mdu_issue_ctrl;
    import mdu_issue_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_valid, e_valid, flush;
    logic [3:0]  d_op, e_op;
    logic        enMDU, rdMDU, start, busy, stall_d;
    logic [3:0]  MDUOp;
    logic [4:0]  remain;
    logic [31:0] stall_cnt;

    int vectors = 0;
    int fails   = 0;

    mdu_issue_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .d_valid   (d_valid),
        .d_op      (d_op),
        .e_valid   (e_valid),
        .e_op      (e_op),
        .flush     (flush),
        .enMDU     (enMDU),
        .rdMDU     (rdMDU),
        .MDUOp     (MDUOp),
        .start     (start),
        .busy      (busy),
        .remain    (remain),
        .stall_d   (stall_d),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Protocol invariant: no live MDU op issues while busy.
    always @(negedge clk) begin
        if (!rst) begin
            assert (!(e_valid && !flush && e_op != 4'd0 && busy)) else begin
                fails++;
                $error("FAIL invariant observed=live_op_while_busy expected=none");
            end
        end
    end

    initial begin
        rst = 1'b1; d_valid = 0; d_op = 0; e_valid = 0; e_op = 0; flush = 0;
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_remain", 32'(remain), 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_mduop", 32'(MDUOp), 0);
        chk("rst_en", 32'({enMDU, rdMDU, start, stall_d}), 0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // 1. MULT launch and 5-cycle countdown
        e_valid = 1; e_op = 4'd1; #1;
        chk("t1_start", 32'(start), 1);
        chk("t1_en", 32'(enMDU), 1);
        chk("t1_op", 32'(MDUOp), 1);
        chk("t1_busy0", 32'(busy), 0);
        next_cycle();
        e_valid = 0; e_op = 0;
        for (int i = 1; i <= 5; i++) begin
            chk("t1_busy", 32'(busy), 1);
            chk("t1_remain", 32'(remain), 32'(6 - i));
            next_cycle();
        end
        chk("t1_busy6", 32'(busy), 0);
        chk("t1_remain6", 32'(remain), 0);

        // 2. DIV with MFLO waiting in D
        e_valid = 1; e_op = 4'd3; d_valid = 1; d_op = 4'd8; #1;
        chk("t2_start", 32'(start), 1);
        chk("t2_stall0", 32'(stall_d), 1);
        next_cycle();
        e_valid = 0; e_op = 0; #1;
        for (int i = 1; i <= 10; i++) begin
            chk("t2_stall", 32'(stall_d), 1);
            chk("t2_remain", 32'(remain), 32'(11 - i));
            next_cycle();
        end
        chk("t2_stall11", 32'(stall_d), 0);
        chk("t2_cnt", stall_cnt, 11);
        next_cycle();
        d_valid = 0; d_op = 0; e_valid = 1; e_op = 4'd8; #1;
        chk("t2_rd", 32'(rdMDU), 1);
        chk("t2_en", 32'(enMDU), 0);
        chk("t2_op", 32'(MDUOp), 8);
        next_cycle();

        // 3a. flushed DIVU never issues
        e_valid = 1; e_op = 4'd4; flush = 1; #1;
        chk("t3_start", 32'(start), 0);
        chk("t3_en", 32'(enMDU), 0);
        chk("t3_op", 32'(MDUOp), 0);
        next_cycle();
        flush = 0; e_valid = 0; e_op = 0;
        chk("t3_busy", 32'(busy), 0);

        // 3b. flush at cycle 3 of a MULTU does not disturb the countdown
        e_valid = 1; e_op = 4'd2; #1;
        chk("t3b_start", 32'(start), 1);
        next_cycle();
        e_valid = 0; e_op = 0;
        next_cycle();
        next_cycle();
        e_valid = 1; e_op = 4'd5; flush = 1; #1;
        chk("t3b_en", 32'(enMDU), 0);
        chk("t3b_remain3", 32'(remain), 3);
        next_cycle();
        e_valid = 0; e_op = 0; flush = 0;
        chk("t3b_remain4", 32'(remain), 2);
        next_cycle();
        chk("t3b_busy5", 32'(busy), 1);
        next_cycle();
        chk("t3b_busy6", 32'(busy), 0);

        // 4. MTHI then MTLO back-to-back, MDU op in D does not stall
        e_valid = 1; e_op = 4'd5; d_valid = 1; d_op = 4'd6; #1;
        chk("t4_en_a", 32'(enMDU), 1);
        chk("t4_stall_a", 32'(stall_d), 0);
        chk("t4_start_a", 32'(start), 0);
        next_cycle();
        e_op = 4'd6; d_valid = 0; d_op = 0; #1;
        chk("t4_en_b", 32'(enMDU), 1);
        chk("t4_op_b", 32'(MDUOp), 6);
        chk("t4_busy", 32'(busy), 0);
        next_cycle();
        e_valid = 0; e_op = 0;
        chk("t4_cnt", stall_cnt, 11);

        // 5. async reset mid-DIV with remain=7
        e_valid = 1; e_op = 4'd3; d_valid = 1; d_op = 4'd7; #1;
        next_cycle();
        e_valid = 0; e_op = 0;
        next_cycle();
        next_cycle();
        next_cycle();
        chk("t5_remain7", 32'(remain), 7);
        chk("t5_cnt_pre", stall_cnt, 15);
        rst = 1; #1;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_remain", 32'(remain), 0);
        chk("t5_cnt", stall_cnt, 0);
        d_valid = 0; d_op = 0;
        next_cycle();
        rst = 0;
        next_cycle();
        e_valid = 1; e_op = 4'd9; #1;
        chk("t5_maddu_start", 32'(start), 1);
        next_cycle();
        e_valid = 0; e_op = 0;
        chk("t5_maddu_remain", 32'(remain), 5);
        for (int i = 0; i < 5; i++) next_cycle();
        chk("t5_idle", 32'(busy), 0);

        // 6. out-of-range op code behaves as NONE
        e_valid = 1; e_op = 4'hF; d_valid = 1; d_op = 4'hF; #1;
        chk("t6_flags", 32'({enMDU, rdMDU, start, stall_d}), 0);
        chk("t6_op", 32'(MDUOp), 0);
        next_cycle();
        e_valid = 0; e_op = 0; d_valid = 0; d_op = 0;
        chk("t6_busy", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
